// File: rtl/line_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers supply the rows above; a per-row two-column history plus the live column forms the window.
module line_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_W      = 28,
    parameter int MAX_H      = 28,
    localparam int WW = $clog2(MAX_W + 1),
    localparam int HW = $clog2(MAX_H + 1),
    localparam int AW = $clog2(MAX_W)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [WW-1:0]           img_w,
    input  logic [HW-1:0]           img_h,
    input  logic                    stride2,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9*DATA_WIDTH-1:0] out_win,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    logic [WW-1:0]             r_cfg_w;
    logic [HW-1:0]             r_cfg_h;
    logic                      r_cfg_s2;
    logic [WW-1:0]             r_col;
    logic [HW-1:0]             r_row;
    logic                      r_out_valid;
    logic [9*DATA_WIDTH-1:0]   r_out_win;
    logic                      r_frame_done;
    logic                      r_cfg_err;

    logic [DATA_WIDTH-1:0]     r_lb0 [MAX_W];
    logic [DATA_WIDTH-1:0]     r_lb1 [MAX_W];
    logic [DATA_WIDTH-1:0]     r_lb0_q;
    logic [DATA_WIDTH-1:0]     r_lb1_q;

    logic                      w_accept;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_emit;
    logic                      w_cfg_ok;
    logic [WW-1:0]             w_col_nxt;
    logic [9*DATA_WIDTH-1:0]   w_win;

    assign in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign busy       = (r_state == S_RUN);
    assign out_valid  = r_out_valid;
    assign out_win    = r_out_win;
    assign frame_done = r_frame_done;
    assign cfg_err    = r_cfg_err;

    assign w_accept   = in_valid && in_ready;
    assign w_last_col = (r_col == r_cfg_w - WW'(1));
    assign w_last_row = (r_row == r_cfg_h - HW'(1));
    assign w_cfg_ok   = (img_w >= WW'(3)) && (img_w <= WW'(MAX_W)) &&
                        (img_h >= HW'(3)) && (img_h <= HW'(MAX_H));
    assign w_emit     = w_accept && (r_row >= HW'(2)) && (r_col >= WW'(2)) &&
                        (!r_cfg_s2 || (!r_row[0] && !r_col[0]));

    // Column the next accepted pixel will land in; the line buffers prefetch it so
    // their registered read is ready exactly when that pixel arrives.
    always_comb begin
        w_col_nxt = r_col;
        if (w_accept)
            w_col_nxt = w_last_col ? '0 : r_col + WW'(1);
    end

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2. Contents are never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col[AW-1:0]] <= in_data;
            r_lb1[r_col[AW-1:0]] <= r_lb0_q;
        end
        r_lb0_q <= r_lb0[w_col_nxt[AW-1:0]];
        r_lb1_q <= r_lb1[w_col_nxt[AW-1:0]];
    end

    // Window row gi: two history columns plus the column arriving now. Stale columns
    // from the previous image row are shifted out before c reaches 2.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [DATA_WIDTH-1:0] r_hist0;
        logic [DATA_WIDTH-1:0] r_hist1;
        logic [DATA_WIDTH-1:0] w_new;

        assign w_new = (gi == 0) ? r_lb1_q : (gi == 1) ? r_lb0_q : in_data;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_hist0 <= '0;
                r_hist1 <= '0;
            end else if (w_accept) begin
                r_hist0 <= r_hist1;
                r_hist1 <= w_new;
            end
        end

        assign w_win[(3*gi+0)*DATA_WIDTH +: DATA_WIDTH] = r_hist0;
        assign w_win[(3*gi+1)*DATA_WIDTH +: DATA_WIDTH] = r_hist1;
        assign w_win[(3*gi+2)*DATA_WIDTH +: DATA_WIDTH] = w_new;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cfg_w      <= '0;
            r_cfg_h      <= '0;
            r_cfg_s2     <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_out_win    <= '0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_cfg_w   <= img_w;
                            r_cfg_h   <= img_h;
                            r_cfg_s2  <= stride2;
                            r_col     <= '0;
                            r_row     <= '0;
                            r_cfg_err <= 1'b0;
                            r_state   <= S_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_col <= w_col_nxt;
                        if (w_last_col) begin
                            r_row <= w_last_row ? '0 : r_row + HW'(1);
                            if (w_last_row)
                                r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_out_valid || out_ready) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Acceptance is gated on a free output slot, so a new window never overwrites a stalled one.
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_win   <= w_win;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Randomized scoreboard bench for line_window_gen: a top-left-stepping window model
// fills an expectation queue; an independent monitor pops and compares each output window.
module tb_line_window_gen;

    localparam int DW = 8;
    localparam int MW = 28;
    localparam int MH = 28;
    localparam int WW = $clog2(MW + 1);
    localparam int HW = $clog2(MH + 1);

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [WW-1:0]     img_w = '0;
    logic [HW-1:0]     img_h = '0;
    logic              stride2 = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [9*DW-1:0]   out_win;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;

    always #5 clk = ~clk;

    line_window_gen #(.DATA_WIDTH(DW), .MAX_W(MW), .MAX_H(MH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .img_w(img_w), .img_h(img_h),
        .stride2(stride2), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    int              n_checks = 0;
    int              n_pass   = 0;
    int              done_cnt = 0;
    int              win_cnt  = 0;
    bit              rand_ready = 1'b0;
    logic [9*DW-1:0] exp_q [$];
    logic [DW-1:0]   pix [$];

    task automatic check(input string name, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        logic [9*DW-1:0] stall_win;
        logic [9*DW-1:0] e;
        bit              stalled;
        stalled = 1'b0;
        stall_win = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stalled = 1'b0;
            end else begin
                if (frame_done) done_cnt++;
                if (stalled) begin
                    check("stall_valid", {71'd0, out_valid}, 72'd1);
                    check("stall_win", out_win, stall_win);
                end
                if (out_valid && out_ready) begin
                    win_cnt++;
                    $display("win %0d: %h", win_cnt, out_win);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_window: got %0h expected none", out_win);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", out_win, e);
                    end
                end
                stalled   = out_valid && !out_ready;
                stall_win = out_win;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic build_pix(input int w, input int h, input bit randpix);
        pix.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix.push_back(randpix ? DW'($urandom) : DW'(5 * r + c));
    endtask

    // Windows listed by top-left corner stepping through the frame in raster order.
    task automatic build_expect(input int w, input int h, input bit s2);
        int step;
        logic [9*DW-1:0] e;
        step = s2 ? 2 : 1;
        for (int tr = 0; tr + 2 < h; tr += step)
            for (int tc = 0; tc + 2 < w; tc += step) begin
                e = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e[(3*i+j)*DW +: DW] = pix[(tr + i) * w + tc + j];
                exp_q.push_back(e);
            end
    endtask

    task automatic do_start(input int w, input int h, input bit s2);
        img_w = WW'(w);
        img_h = HW'(h);
        stride2 = s2;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit poke);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 20000) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = pix[idx];
            if (poke && idx == 10) begin
                start = 1'b1;
                img_w = WW'(3);
                img_h = HW'(3);
                stride2 = ~stride2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("pixels_accepted", 72'(idx), 72'(n));
    endtask

    task automatic run_frame(input int w, input int h, input bit s2, input bit randpix, input bit poke);
        int d0;
        int w0;
        int nexp;
        int k;
        nexp = s2 ? ((h - 1) / 2) * ((w - 1) / 2) : (h - 2) * (w - 2);
        build_pix(w, h, randpix);
        build_expect(w, h, s2);
        d0 = done_cnt;
        w0 = win_cnt;
        do_start(w, h, s2);
        check("busy_after_start", {71'd0, busy}, 72'd1);
        check("cfg_err_after_start", {71'd0, cfg_err}, 72'd0);
        feed(w * h, poke);
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            tick();
            k++;
        end
        repeat (5) tick();
        check("frame_done_count", 72'(done_cnt - d0), 72'd1);
        check("window_count", 72'(win_cnt - w0), 72'(nexp));
        check("queue_drained", 72'(exp_q.size()), 72'd0);
        check("busy_after_frame", {71'd0, busy}, 72'd0);
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, {71'd0, in_ready}, 72'd0);
        check({tag, "_out_valid"}, {71'd0, out_valid}, 72'd0);
        check({tag, "_busy"}, {71'd0, busy}, 72'd0);
        check({tag, "_frame_done"}, {71'd0, frame_done}, 72'd0);
        check({tag, "_cfg_err"}, {71'd0, cfg_err}, 72'd0);
        check({tag, "_out_win"}, out_win, 72'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        resetn = 1'b1;
        tick();

        // Pixels offered while idle must be refused.
        in_valid = 1'b1;
        repeat (4) tick();
        check("idle_in_ready", {71'd0, in_ready}, 72'd0);
        in_valid = 1'b0;

        run_frame(5, 5, 1'b0, 1'b0, 1'b0);
        run_frame(5, 5, 1'b1, 1'b0, 1'b0);

        do_start(2, 5, 1'b0);
        check("bad_cfg_err", {71'd0, cfg_err}, 72'd1);
        check("bad_cfg_busy", {71'd0, busy}, 72'd0);
        check("bad_cfg_in_ready", {71'd0, in_ready}, 72'd0);
        repeat (3) tick();
        check("bad_cfg_err_hold", {71'd0, cfg_err}, 72'd1);
        resetn = 1'b0;
        tick();
        check("reset_clears_cfg_err", {71'd0, cfg_err}, 72'd0);
        resetn = 1'b1;
        tick();
        do_start(5, 2, 1'b0);
        check("bad_h_cfg_err", {71'd0, cfg_err}, 72'd1);
        run_frame(5, 5, 1'b0, 1'b0, 1'b0);

        rand_ready = 1'b1;
        run_frame(28, 28, 1'b0, 1'b1, 1'b0);
        run_frame(7, 6, 1'b1, 1'b1, 1'b0);
        rand_ready = 1'b0;
        tick();

        // Abort a frame after 12 pixels; no window is due yet.
        build_pix(5, 5, 1'b0);
        do_start(5, 5, 1'b0);
        feed(12, 1'b0);
        resetn = 1'b0;
        tick();
        check_quiet("midreset");
        tick();
        resetn = 1'b1;
        tick();
        run_frame(5, 5, 1'b0, 1'b0, 1'b0);

        run_frame(5, 5, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
